// File: rtl/mpmodadd_ctrl.sv
// Modular add/subtract sequencer: drives the shared 514-bit mpadder for one or two
// passes to produce (A+B) mod M or (A-B) mod M, with a per-pass watchdog.
module mpmodadd_ctrl #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic         clk_i,
  input  logic         resetn_i,
  input  logic         start_i,
  input  logic         op_i,
  input  logic [513:0] in_a_i,
  input  logic [513:0] in_b_i,
  input  logic [513:0] in_m_i,
  output logic         busy_o,
  output logic         done_o,
  output logic         err_o,
  output logic [513:0] result_o,
  output logic         adder_start_o,
  output logic         adder_subtract_o,
  output logic [513:0] adder_a_o,
  output logic [513:0] adder_b_o,
  input  logic [514:0] adder_result_i,
  input  logic         adder_done_i
);

  localparam int W = 514;
  localparam logic [7:0] WD_LAST = 8'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_P1_START,
    S_P1_WAIT,
    S_P2_START,
    S_P2_WAIT,
    S_DONE
  } state_e;

  state_e         state_q, state_d;
  logic           op_q, op_d;
  logic [W-1:0]   m_q, m_d;
  logic [W-1:0]   r1_q, r1_d;
  logic [7:0]     wd_q, wd_d;
  logic           err_q, err_d;
  logic [W-1:0]   result_q, result_d;
  logic           adder_start_q, adder_start_d;
  logic           sub_q, sub_d;
  logic [W-1:0]   a_q, a_d;
  logic [W-1:0]   b_q, b_d;

  logic           wd_hit;
  logic           p1_finishes;

  assign wd_hit = (wd_q == WD_LAST);
  // First pass is final on an add overflow (range error) or a subtract without borrow.
  assign p1_finishes = (op_q ^ adder_result_i[W]);

  // State register
  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start_i) state_d = S_P1_START;
      end
      S_P1_START: state_d = S_P1_WAIT;
      S_P1_WAIT: begin
        if (adder_done_i) begin
          state_d = p1_finishes ? S_DONE : S_P2_START;
        end else if (wd_hit) begin
          state_d = S_DONE;
        end
      end
      S_P2_START: state_d = S_P2_WAIT;
      S_P2_WAIT: begin
        if (adder_done_i || wd_hit) state_d = S_DONE;
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs decoded from state
  always_comb begin
    busy_o = (state_q != S_IDLE);
    done_o = (state_q == S_DONE);
  end

  // Datapath next values: operand latch, pass results, watchdog and final result
  always_comb begin
    op_d          = op_q;
    m_d           = m_q;
    r1_d          = r1_q;
    wd_d          = wd_q;
    err_d         = err_q;
    result_d      = result_q;
    adder_start_d = 1'b0;
    sub_d         = sub_q;
    a_d           = a_q;
    b_d           = b_q;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          op_d          = op_i;
          m_d           = in_m_i;
          a_d           = in_a_i;
          b_d           = in_b_i;
          sub_d         = op_i;
          err_d         = 1'b0;
          wd_d          = 8'd0;
          adder_start_d = 1'b1;
        end
      end
      S_P1_WAIT: begin
        if (adder_done_i) begin
          r1_d = adder_result_i[W-1:0];
          if (p1_finishes) begin
            if (op_q) begin
              result_d = adder_result_i[W-1:0];
            end else begin
              err_d    = 1'b1;
              result_d = '0;
            end
          end
        end else if (wd_hit) begin
          err_d    = 1'b1;
          result_d = '0;
        end else begin
          wd_d = wd_q + 8'd1;
        end
      end
      S_P2_START: begin
        // Second-pass operands come from the registered R1, so its adder_start trails by a cycle.
        a_d           = r1_q;
        b_d           = m_q;
        sub_d         = ~op_q;
        wd_d          = 8'd0;
        adder_start_d = 1'b1;
      end
      S_P2_WAIT: begin
        if (adder_done_i) begin
          if (!op_q && adder_result_i[W]) begin
            result_d = r1_q;
          end else begin
            result_d = adder_result_i[W-1:0];
          end
        end else if (wd_hit) begin
          err_d    = 1'b1;
          result_d = '0;
        end else begin
          wd_d = wd_q + 8'd1;
        end
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      op_q          <= 1'b0;
      m_q           <= '0;
      r1_q          <= '0;
      wd_q          <= 8'd0;
      err_q         <= 1'b0;
      result_q      <= '0;
      adder_start_q <= 1'b0;
      sub_q         <= 1'b0;
      a_q           <= '0;
      b_q           <= '0;
    end else begin
      op_q          <= op_d;
      m_q           <= m_d;
      r1_q          <= r1_d;
      wd_q          <= wd_d;
      err_q         <= err_d;
      result_q      <= result_d;
      adder_start_q <= adder_start_d;
      sub_q         <= sub_d;
      a_q           <= a_d;
      b_q           <= b_d;
    end
  end

  assign err_o            = err_q;
  assign result_o         = result_q;
  assign adder_start_o    = adder_start_q;
  assign adder_subtract_o = sub_q;
  assign adder_a_o        = a_q;
  assign adder_b_o        = b_q;

endmodule
